uart_word_rx: RTL
=================

// Module: uart_word_rx
// PURPOSE
//  Serial loader front-end: receives 8N1 UART bytes on rxd and assembles them into WIDTH-bit words.
//  Presents each completed word on word with a one-cycle word_valid pulse.
//  Sits directly upstream of a WIDTH-bit enable register: word -> inp, word_valid -> enable.
//  Used for program/data load into the core.
// PARAMETERS
//  CLKS_PER_BIT  `UART_CLKS_PER_BIT (868)  clk cycles per serial bit; must be >= 4
//  WIDTH         `WIDTH (from common.h)    word width; must be a multiple of 8
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rstn        in   1      reset; asynchronous, active-low
//  rxd         in   1      UART serial input; idle high; asynchronous to clk
//  word        out  WIDTH  last completed word; held until the next word completes
//  word_valid  out  1      one-cycle pulse: word is new this cycle
//  frame_err   out  1      sticky: stop bit (or parity) error seen
//  err_clr     in   1      clears frame_err
//  busy        out  1      high whenever FSM is not in IDLE
// BEHAVIOUR
//  Reset: word=0, word_valid=0, frame_err=0, busy=0, byte_idx=0, FSM=IDLE, rxd synchroniser=1.
//  rxd passes through a 2-flop synchroniser; all sampling uses the synchronised value rxs.
//  FSM states: IDLE, START, DATA, [PARITY], STOP, RECOVER. Bit counter cnt counts 0..CLKS_PER_BIT-1.
//  - IDLE: rxs==0 -> START, cnt=0.
//  - START: at cnt==CLKS_PER_BIT/2-1, sample rxs.
//    - rxs==1: false start -> IDLE.
//    - else: cnt=0 -> DATA, bit=0.
//  - DATA: sample at cnt==CLKS_PER_BIT-1, LSB first; after bit 7 -> PARITY (feature on) or STOP.
//  - STOP: sample at cnt==CLKS_PER_BIT-1.
//    - rxs==1: byte accepted -> IDLE.
//    - rxs==0: frame_err=1, byte dropped, byte_idx=0 -> RECOVER.
//  - RECOVER: wait for rxs==1 -> IDLE. A held-low line (break) never starts a new frame.
//  Assembly: little-endian; first accepted byte -> word[7:0], byte_idx-th byte -> [8*i+7:8*i].
//    Bytes accumulate in an internal shift buffer, not in word.
//  When byte WIDTH/8-1 is accepted, word is loaded from the buffer.
//    word_valid=1 in the cycle after the stop-bit sample clock edge; byte_idx wraps to 0.
//  word_valid is never asserted for 2 consecutive cycles.
//  Latency, stop sample of last byte -> word_valid: 1 cycle.
//  frame_err: err_clr on the same cycle as a new error -> error wins (stays 1).
//  Reset mid-frame: FSM and partial word discarded immediately; the next frame starts at byte 0.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY state inserted after DATA; samples one even-parity bit.
//    - Mismatch: frame_err=1, byte dropped, byte_idx=0, stop bit still consumed (-> STOP, no further error).
//  Undefined: no parity bit; DATA -> STOP directly; frame = 10 bits.
// STRUCTURE
//  common.h: `WIDTH, `UART_CLKS_PER_BIT. FSM encodings are localparams in the RTL.
//  Sub-module uart_byte_rx: synchroniser + FSM; outputs byte[7:0], byte_valid, byte_err.
//  uart_word_rx: byte assembly, byte_idx, word/word_valid, sticky frame_err.
// TESTING  (CLKS_PER_BIT=16, WIDTH=32)
//  1. Send 0x78,0x56,0x34,0x12 back-to-back -> exactly one word_valid pulse with word=0x12345678;
//     busy=0 afterwards.
//  2. rxd low for 4 cycles then high -> no byte; busy returns 0 within 8 cycles; word unchanged.
//  3. Send 0x11, then 0x22 with stop=0, then 0x33,0x44,0x55,0x66 -> frame_err=1;
//     first pulse has word=0x66554433.
//  4. rstn low for 3 cycles during DATA of byte 2 -> word=0, word_valid=0, frame_err=0;
//     then 4 bytes 0xEF,0xBE,0xAD,0xDE -> word=0xDEADBEEF.
//  5. err_clr on the same cycle as a stop-bit error -> frame_err=1;
//     err_clr alone next cycle -> frame_err=0.
//  6. With UART_RX_PARITY_EN: 0xA5 with parity bit 1 -> frame_err=1, byte dropped;
//     0xA5 with parity bit 0 accepted.

Source files
------------

// File: rtl/uart_word_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_word_rx_pkg
// Shared definitions for the UART word loader: default parameter values
// (UART clocks per bit and word width),
// the receiver state encoding and the even-parity helper.
// -----------------------------------------------------------------------------
package uart_word_rx_pkg;

   localparam int DEF_CLKS_PER_BIT = 868;
   localparam int DEF_WIDTH        = 32;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_PARITY  = 3'd3,
      RX_STOP    = 3'd4,
      RX_RECOVER = 3'd5
   } rx_state_t;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// -----------------------------------------------------------------------------
// uart_word_rx_if
// Bundles the loader's serial input and word-side outputs.
//   rxd        serial input, idle high
//   err_clr    clears the sticky frame error
//   word       last completed WIDTH-bit word
//   word_valid one-cycle pulse when word is new
//   frame_err  sticky stop/parity error flag
//   busy       receiver is inside a frame
// Modports: master = the receiver (drives word side), slave = its user.
// -----------------------------------------------------------------------------
interface uart_word_rx_if
   import uart_word_rx_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH);

   logic             rxd;
   logic             err_clr;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             frame_err;
   logic             busy;

   modport master (
      input  rxd, err_clr,
      output word, word_valid, frame_err, busy
   );

   modport slave (
      output rxd, err_clr,
      input  word, word_valid, frame_err, busy
   );

endinterface

// File: rtl/uart_word_rx_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 (optionally 8E1) UART byte receiver: 2-flop synchroniser plus frame FSM.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit).
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   rxd         raw serial input (asynchronous to clk)
//   data        received byte, valid while byte_valid is high
//   byte_valid  strobe on the stop-bit sample edge of a good frame
//   byte_err    strobe on the edge that detects a bad stop or parity bit
//   busy        FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_byte_rx
   import uart_word_rx_pkg::*;
   #(parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT)
   (
      input  logic       clk,
      input  logic       rstn,
      input  logic       rxd,
      output logic [7:0] data,
      output logic       byte_valid,
      output logic       byte_err,
      output logic       busy
   );

   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             rx_meta;
   logic             rxs;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             par_bad;
   logic             bit_tick;
   logic             parity_strobe;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   assign bit_tick = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
   assign parity_strobe = (state == RX_PARITY) && bit_tick && (rxs != even_parity(shreg));
`else
   assign parity_strobe = 1'b0;
`endif

   // Strobes are decoded from the sample edge itself so the word stage can
   // register the result one cycle after the stop-bit sample.  A frame that
   // already failed parity reports nothing further at its stop bit.
   assign byte_valid = (state == RX_STOP) && bit_tick && rxs && !par_bad;
   assign byte_err   = ((state == RX_STOP) && bit_tick && !rxs && !par_bad) || parity_strobe;
   assign data       = shreg;
   assign busy       = (state != RX_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else begin
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               par_bad <= 1'b0;
               if (!rxs) state <= RX_START;
            end
            RX_START: begin
               // Mid-bit check rejects glitches shorter than half a bit.
               if (cnt == CNT_HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  shreg <= {rxs, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= RX_PARITY;
`else
                     state <= RX_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
               if (bit_tick) begin
                  cnt     <= '0;
                  par_bad <= (rxs != even_parity(shreg));
                  state   <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  state <= rxs ? RX_IDLE : RX_RECOVER;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_RECOVER: begin
               // A held-low line (break) must go high before a new start bit counts.
               cnt <= '0;
               if (rxs) state <= RX_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_word_rx.sv
// -----------------------------------------------------------------------------
// uart_word_rx
// Serial loader front-end: receives UART bytes and assembles them,
// little-endian, into WIDTH-bit words presented with a one-cycle word_valid.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit per byte).
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   uart_word_rx_if.master: rxd, err_clr in; word, word_valid,
//         frame_err, busy out
// -----------------------------------------------------------------------------
module uart_word_rx
   import uart_word_rx_pkg::*;
   #(
      parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
      parameter int WIDTH        = DEF_WIDTH
   )
   (
      input  logic           clk,
      input  logic           rstn,
      uart_word_rx_if.master bus
   );

   localparam int               NBYTES   = WIDTH / 8;
   localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   logic [7:0]       rx_data;
   logic             byte_valid;
   logic             byte_err;
   logic             rx_busy;
   logic [WIDTH-1:0] buffer;
   logic [WIDTH-1:0] buf_next;
   logic [IDX_W-1:0] byte_idx;
   logic [WIDTH-1:0] word_q;
   logic             word_valid_q;
   logic             frame_err_q;

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
      .clk        (clk),
      .rstn       (rstn),
      .rxd        (bus.rxd),
      .data       (rx_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err),
      .busy       (rx_busy)
   );

   always_comb begin
      buf_next = buffer;
      buf_next[{byte_idx, 3'b000} +: 8] = rx_data;
   end

   // Stale bytes in the buffer are harmless: byte_idx restarts at 0 and each
   // slot is overwritten before the word is published.
   always_ff @(posedge clk) begin
      if (byte_valid) buffer <= buf_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         byte_idx     <= '0;
      end else begin
         word_valid_q <= 1'b0;

         // A new error beats a simultaneous clear.
         if (byte_err) begin
            frame_err_q <= 1'b1;
            byte_idx    <= '0;
         end else if (bus.err_clr) begin
            frame_err_q <= 1'b0;
         end

         if (byte_valid) begin
            if (byte_idx == LAST_IDX) begin
               word_q       <= buf_next;
               word_valid_q <= 1'b1;
               byte_idx     <= '0;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end

   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = rx_busy;

endmodule
